// File: rtl/stage_memory_resp_if.sv
// Bus bundle for the memory stage: execute-side handshake,
// data-memory req/done channel and writeback handshake.
interface stage_memory_resp_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              ex_valid;
    logic              ex_ready;
    logic [ADDR_W-1:0] ex_alu_result;
    logic [DATA_W-1:0] ex_wdata;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic [2:0]        ex_write_reg;
    logic              ex_reg_write;
    logic              ex_halt;

    logic              mem_req;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_err;

    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_data;
    logic [2:0]        wb_write_reg;
    logic              wb_reg_write;
    logic              wb_halt;

    modport slave (
        input  ex_valid, ex_alu_result, ex_wdata,
        input  ex_mem_read, ex_mem_write,
        input  ex_write_reg, ex_reg_write, ex_halt,
        output ex_ready,
        output mem_req, mem_wr, mem_addr, mem_wdata,
        input  mem_done, mem_rdata, mem_err,
        output wb_valid, wb_data, wb_write_reg,
        output wb_reg_write, wb_halt,
        input  wb_ready
    );

    modport master (
        output ex_valid, ex_alu_result, ex_wdata,
        output ex_mem_read, ex_mem_write,
        output ex_write_reg, ex_reg_write, ex_halt,
        input  ex_ready,
        input  mem_req, mem_wr, mem_addr, mem_wdata,
        output mem_done, mem_rdata, mem_err,
        input  wb_valid, wb_data, wb_write_reg,
        input  wb_reg_write, wb_halt,
        output wb_ready
    );
endinterface

// File: rtl/stage_memory_resp.sv
// Memory stage: passes ALU results through, runs loads/stores
// on a multi-cycle memory, flags misaligned/faulting/hung accesses.
module stage_memory_resp #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    stage_memory_resp_if.slave  bus,
    output logic                err
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        OUT,
        ERR
    } state_t;

    state_t            st_q, st_d;
    logic              req_q, req_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic              wbv_q, wbv_d;
    logic [DATA_W-1:0] wbd_q, wbd_d;
    logic [2:0]        wreg_q, wreg_d;
    logic              rw_q, rw_d;
    logic              halt_q, halt_d;
    logic              err_q, err_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic accept;
    logic is_mem;

    assign bus.ex_ready = (st_q == IDLE) |
                          ((st_q == OUT) & bus.wb_ready);
    assign accept = bus.ex_valid & bus.ex_ready;
    assign is_mem = bus.ex_mem_read | bus.ex_mem_write;

    assign bus.mem_req      = req_q;
    assign bus.mem_wr       = wr_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdat_q;
    assign bus.wb_valid     = wbv_q;
    assign bus.wb_data      = wbd_q;
    assign bus.wb_write_reg = wreg_q;
    assign bus.wb_reg_write = rw_q;
    assign bus.wb_halt      = halt_q;
    assign err              = err_q;

    // State and output registers; reset abandons any request
    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q   <= IDLE;
            req_q  <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            wdat_q <= '0;
            wbv_q  <= 1'b0;
            wbd_q  <= '0;
            wreg_q <= '0;
            rw_q   <= 1'b0;
            halt_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            st_q   <= st_d;
            req_q  <= req_d;
            wr_q   <= wr_d;
            addr_q <= addr_d;
            wdat_q <= wdat_d;
            wbv_q  <= wbv_d;
            wbd_q  <= wbd_d;
            wreg_q <= wreg_d;
            rw_q   <= rw_d;
            halt_q <= halt_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        st_d   = st_q;
        req_d  = req_q;
        wr_d   = wr_q;
        addr_d = addr_q;
        wdat_d = wdat_q;
        wbv_d  = wbv_q;
        wbd_d  = wbd_q;
        wreg_d = wreg_q;
        rw_d   = rw_q;
        halt_d = halt_q;
        err_d  = err_q;
        cnt_d  = cnt_q;

        unique case (st_q)
            IDLE, OUT: begin
                if (accept) begin
                    if (bus.ex_mem_read & bus.ex_mem_write) begin
                        st_d  = ERR;
                        err_d = 1'b1;
                        req_d = 1'b0;
                        wbv_d = 1'b0;
                    end else if (is_mem & bus.ex_alu_result[0]) begin
                        st_d  = ERR;
                        err_d = 1'b1;
                        req_d = 1'b0;
                        wbv_d = 1'b0;
                    end else begin
                        wreg_d = bus.ex_write_reg;
                        rw_d   = bus.ex_reg_write;
                        halt_d = bus.ex_halt;
                        if (is_mem) begin
                            st_d   = ACCESS;
                            req_d  = 1'b1;
                            wr_d   = bus.ex_mem_write;
                            addr_d = bus.ex_alu_result;
                            wdat_d = bus.ex_wdata;
                            cnt_d  = '0;
                            wbv_d  = 1'b0;
                        end else begin
                            st_d  = OUT;
                            wbv_d = 1'b1;
                            wbd_d = DATA_W'(bus.ex_alu_result);
                        end
                    end
                end else if (st_q == OUT && bus.wb_ready) begin
                    st_d  = IDLE;
                    wbv_d = 1'b0;
                end
            end
            ACCESS: begin
                if (bus.mem_err) begin
                    st_d  = ERR;
                    err_d = 1'b1;
                    req_d = 1'b0;
                end else if (bus.mem_done) begin
                    st_d  = OUT;
                    req_d = 1'b0;
                    wbv_d = 1'b1;
                    if (wr_q) begin
                        wbd_d = DATA_W'(addr_q);
                        rw_d  = 1'b0;
                    end else begin
                        wbd_d = bus.mem_rdata;
                    end
                end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
                    st_d  = ERR;
                    err_d = 1'b1;
                    req_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ERR: begin
                err_d = 1'b1;
                req_d = 1'b0;
                wbv_d = 1'b0;
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_stage_memory_resp.sv
// Directed bench for the memory stage: pass-through, load,
// store, back-pressure, error paths and reset mid-access.
module tb_stage_memory_resp;
    logic clk;
    logic rst;
    logic err;
    int   checks;
    int   failures;
    int   n;

    stage_memory_resp_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    stage_memory_resp #(
        .DATA_W(16), .ADDR_W(16), .MAX_WAIT(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .err(err)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        bus.ex_valid      = 1'b0;
        bus.ex_alu_result = '0;
        bus.ex_wdata      = '0;
        bus.ex_mem_read   = 1'b0;
        bus.ex_mem_write  = 1'b0;
        bus.ex_write_reg  = '0;
        bus.ex_reg_write  = 1'b0;
        bus.ex_halt       = 1'b0;
        bus.mem_done      = 1'b0;
        bus.mem_rdata     = '0;
        bus.mem_err       = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic issue_load(input logic [15:0] a);
        bus.ex_valid      = 1'b1;
        bus.ex_mem_read   = 1'b1;
        bus.ex_alu_result = a;
        bus.ex_write_reg  = 3'd5;
        bus.ex_reg_write  = 1'b1;
        tick();
        idle_in();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        idle_in();
        bus.wb_ready = 1'b1;
        tick();
        tick();
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_ex_ready", bus.ex_ready, 1);
        rst = 1'b1;
        tick();

        // ALU pass-through, stream of four
        bus.ex_valid     = 1'b1;
        bus.ex_write_reg = 3'd3;
        bus.ex_reg_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.ex_alu_result = 16'h1234 + 16'(i);
            tick();
            chk("alu_valid", bus.wb_valid, 1);
            chk("alu_data", bus.wb_data, 32'h1234 + i);
            chk("alu_reg", bus.wb_write_reg, 3);
            chk("alu_rw", bus.wb_reg_write, 1);
        end
        idle_in();
        tick();
        chk("alu_drain", bus.wb_valid, 0);

        // Load with done on third request cycle
        issue_load(16'h0040);
        for (int i = 0; i < 3; i++) begin
            chk("ld_req", bus.mem_req, 1);
            chk("ld_wr", bus.mem_wr, 0);
            chk("ld_addr", bus.mem_addr, 32'h40);
            chk("ld_exrdy", bus.ex_ready, 0);
            chk("ld_wbv", bus.wb_valid, 0);
            if (i == 2) begin
                bus.mem_done  = 1'b1;
                bus.mem_rdata = 16'hBEEF;
            end
            tick();
        end
        idle_in();
        chk("ld_req_drop", bus.mem_req, 0);
        chk("ld_wbv", bus.wb_valid, 1);
        chk("ld_data", bus.wb_data, 32'hBEEF);
        chk("ld_reg", bus.wb_write_reg, 5);
        chk("ld_rw", bus.wb_reg_write, 1);
        tick();
        chk("ld_drain", bus.wb_valid, 0);

        // Store
        bus.ex_valid      = 1'b1;
        bus.ex_mem_write  = 1'b1;
        bus.ex_alu_result = 16'h0010;
        bus.ex_wdata      = 16'h00AA;
        bus.ex_write_reg  = 3'd1;
        bus.ex_reg_write  = 1'b1;
        tick();
        idle_in();
        chk("st_req", bus.mem_req, 1);
        chk("st_wr", bus.mem_wr, 1);
        chk("st_addr", bus.mem_addr, 32'h10);
        chk("st_wdata", bus.mem_wdata, 32'hAA);
        bus.mem_done = 1'b1;
        tick();
        idle_in();
        chk("st_wbv", bus.wb_valid, 1);
        chk("st_rw", bus.wb_reg_write, 0);
        chk("st_data", bus.wb_data, 32'h10);

        // Back-pressure in OUT, then accept with wb_ready
        bus.wb_ready = 1'b0;
        #1;
        chk("bp_exrdy0", bus.ex_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_wbv", bus.wb_valid, 1);
            chk("bp_data", bus.wb_data, 32'h10);
            chk("bp_exrdy", bus.ex_ready, 0);
        end
        bus.wb_ready      = 1'b1;
        bus.ex_valid      = 1'b1;
        bus.ex_alu_result = 16'h5555;
        bus.ex_write_reg  = 3'd2;
        bus.ex_reg_write  = 1'b1;
        #1;
        chk("bp_exrdy1", bus.ex_ready, 1);
        tick();
        idle_in();
        chk("bp_wbv2", bus.wb_valid, 1);
        chk("bp_data2", bus.wb_data, 32'h5555);
        chk("bp_reg2", bus.wb_write_reg, 2);
        tick();
        chk("bp_drain", bus.wb_valid, 0);

        // Misaligned load
        issue_load(16'h0041);
        chk("mis_err", err, 1);
        chk("mis_req", bus.mem_req, 0);
        chk("mis_exrdy", bus.ex_ready, 0);
        tick();
        chk("mis_sticky", err, 1);
        chk("mis_req2", bus.mem_req, 0);
        do_reset();
        chk("mis_clr", err, 0);
        chk("mis_clr_rdy", bus.ex_ready, 1);

        // Load and store both set
        bus.ex_valid      = 1'b1;
        bus.ex_mem_read   = 1'b1;
        bus.ex_mem_write  = 1'b1;
        bus.ex_alu_result = 16'h0020;
        tick();
        idle_in();
        chk("both_err", err, 1);
        chk("both_req", bus.mem_req, 0);
        do_reset();

        // Timeout: no response for MAX_WAIT cycles
        issue_load(16'h0040);
        n = 0;
        for (int i = 0; i < 40 && bus.mem_req === 1'b1; i++) begin
            n++;
            tick();
        end
        chk("to_cycles", n, 15);
        chk("to_err", err, 1);
        chk("to_wbv", bus.wb_valid, 0);
        do_reset();
        chk("to_clr", err, 0);

        // mem_err together with mem_done
        issue_load(16'h0040);
        bus.mem_err   = 1'b1;
        bus.mem_done  = 1'b1;
        bus.mem_rdata = 16'h1111;
        tick();
        idle_in();
        chk("merr_err", err, 1);
        chk("merr_wbv", bus.wb_valid, 0);
        chk("merr_req", bus.mem_req, 0);
        do_reset();
        chk("merr_clr", err, 0);

        // Reset mid-access
        issue_load(16'h0040);
        chk("rma_req", bus.mem_req, 1);
        do_reset();
        chk("rma_req0", bus.mem_req, 0);
        chk("rma_exrdy", bus.ex_ready, 1);
        chk("rma_err", err, 0);
        chk("rma_wbv", bus.wb_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
